// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into a hold vector, sequences
// recovery flushes with a redirect PC, and tracks stall statistics/timeouts.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam int unsigned RunW = $clog2(MAX_STALL + 1);
  localparam logic [RunW-1:0] MaxRun = RunW'(MAX_STALL);
  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             timeout_q, timeout_d;

  // Zero-latency stall vector; the deepest requesting stage wins, WB never held.
  always_comb begin
    stall = 6'b000000;
    if (!rst && state_q == StRun) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

  // Flush sequencing: accept a request in RUN, then hold flush for FLUSH_CYCLES.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    unique case (state_q)
      StRun: begin
        if (flush_req) begin
          state_d     = StFlush;
          flush_cnt_d = FlushLoad;
          new_pc_d    = flush_pc;
        end
      end
      StFlush: begin
        // Requests arriving mid-flush are dropped; new_pc stays put.
        if (flush_cnt_q == 4'd1) state_d = StRun;
        flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = StRun;
    endcase
    if (rst) begin
      state_d     = StRun;
      flush_cnt_d = '0;
      new_pc_d    = '0;
    end
  end

  // Stall bookkeeping: saturating total count, run length and sticky timeout.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_d       = '0;
    if (|stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      run_d = (run_q == MaxRun) ? run_q : run_q + RunW'(1);
    end
    timeout_d = timeout_q | (run_d == MaxRun);
    if (rst) begin
      stall_cnt_d = '0;
      run_d       = '0;
      timeout_d   = 1'b0;
    end
  end

  // State registers; reset is already folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    flush_cnt_q <= flush_cnt_d;
    new_pc_q    <= new_pc_d;
    stall_cnt_q <= stall_cnt_d;
    run_q       <= run_d;
    timeout_q   <= timeout_d;
  end

  assign flush         = (state_q == StFlush);
  assign new_pc        = new_pc_q;
  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = timeout_q;

endmodule
